// File: rtl/buttons_debouncer.sv
// Four-channel push-button conditioner: 2-FF sync, polarity normalisation and a
// per-channel counter debounce FSM producing a clean level plus press/release pulses.

module buttons_debouncer_lane #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic sample_i,
  output logic btn_o,
  output logic pressed_o,
  output logic released_o
);
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} state_e;

  // The edge that leaves IDLE/HELD already sees the new level, so it counts as the
  // first stable cycle; the terminal count is therefore one short of STABLE_CYCLES-1.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_CYCLES - 2);

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 btn_q, btn_d;
  logic                 pressed_q, pressed_d;
  logic                 released_q, released_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      btn_q      <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      btn_q      <= btn_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    btn_d      = btn_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        btn_d = 1'b0;
        if (sample_i) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!sample_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = HELD;
          btn_d     = 1'b1;
          pressed_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        btn_d = 1'b1;
        if (!sample_i) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (sample_i) begin
          state_d = HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          btn_d      = 1'b0;
          released_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        btn_d   = 1'b0;
      end
    endcase
  end

  assign btn_o      = btn_q;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;
endmodule

module buttons_debouncer #(
  parameter int STABLE_CYCLES = 500000,
  parameter int CNT_WIDTH     = 20,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] raw_btn_i,
  output logic [3:0] btn_o,
  output logic [3:0] pressed_o,
  output logic [3:0] released_o
);
  localparam int         NUM_BTN  = 4;
  localparam logic [3:0] IDLE_LVL = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [NUM_BTN-1:0] s1_q, s2_q, sample;

  // Sync stages reset to the released pin level so reset release produces no pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q <= IDLE_LVL;
      s2_q <= IDLE_LVL;
    end else begin
      s1_q <= raw_btn_i;
      s2_q <= s1_q;
    end
  end

  assign sample = s2_q ^ IDLE_LVL;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_lane
    buttons_debouncer_lane #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst       (rst),
      .sample_i  (sample[i]),
      .btn_o     (btn_o[i]),
      .pressed_o (pressed_o[i]),
      .released_o(released_o[i])
    );
  end
endmodule

// File: tb/tb_buttons_debouncer.sv
// Directed bench for buttons_debouncer with STABLE_CYCLES=8, active-low pins:
// a vector table for clean presses/releases plus hand sequences for bounce and reset.

module tb_buttons_debouncer;
  localparam int SC = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] raw_btn;
  logic [3:0] btn, pressed, released;

  always #5 clk = ~clk;

  buttons_debouncer #(
    .STABLE_CYCLES(SC),
    .CNT_WIDTH    (4),
    .ACTIVE_LOW   (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_btn_i (raw_btn),
    .btn_o     (btn),
    .pressed_o (pressed),
    .released_o(released)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] raw;
    int         n;
    logic [3:0] b;
    logic [3:0] p;
    logic [3:0] r;
  } vec_t;

  vec_t tbl[13];

  task automatic chk(input string nm, input logic [3:0] got, input logic [3:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string nm, input logic [3:0] b, input logic [3:0] p, input logic [3:0] r);
    chk({nm, ".btn"}, btn, b);
    chk({nm, ".pressed"}, pressed, p);
    chk({nm, ".released"}, released, r);
  endtask

  initial begin
    int pulses;
    // {raw pins, edges to run, expected btn, pressed, released}
    tbl[0]  = '{4'hE, SC+1, 4'h0, 4'h0, 4'h0};
    tbl[1]  = '{4'hE, 1,    4'h1, 4'h1, 4'h0};
    tbl[2]  = '{4'hE, 1,    4'h1, 4'h0, 4'h0};
    tbl[3]  = '{4'hF, SC+1, 4'h1, 4'h0, 4'h0};
    tbl[4]  = '{4'hF, 1,    4'h0, 4'h0, 4'h1};
    tbl[5]  = '{4'hF, 1,    4'h0, 4'h0, 4'h0};
    tbl[6]  = '{4'h0, SC+1, 4'h0, 4'h0, 4'h0};
    tbl[7]  = '{4'h0, 1,    4'hF, 4'hF, 4'h0};
    tbl[8]  = '{4'h0, 1,    4'hF, 4'h0, 4'h0};
    tbl[9]  = '{4'hF, SC+2, 4'h0, 4'h0, 4'hF};
    tbl[10] = '{4'hF, 1,    4'h0, 4'h0, 4'h0};
    tbl[11] = '{4'hB, SC+2, 4'h4, 4'h4, 4'h0};
    tbl[12] = '{4'hB, 1,    4'h4, 4'h0, 4'h0};

    // reset with all pins released, then idle for 50 cycles
    raw_btn = 4'hF;
    rst     = 1'b1;
    tick(3);
    chk_all("reset", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    for (int i = 0; i < 50; i++) begin
      tick(1);
      chk_all($sformatf("idle%0d", i), 4'h0, 4'h0, 4'h0);
    end

    for (int v = 0; v < 13; v++) begin
      raw_btn = tbl[v].raw;
      tick(tbl[v].n);
      chk_all($sformatf("vec%0d", v), tbl[v].b, tbl[v].p, tbl[v].r);
    end

    // btn2 held: release with bounces, then settle high
    for (int k = 0; k < 4; k++) begin
      raw_btn = k[0] ? 4'hB : 4'hF;
      for (int j = 0; j < 3; j++) begin
        tick(1);
        chk_all($sformatf("bounce%0d_%0d", k, j), 4'h4, 4'h0, 4'h0);
      end
    end
    raw_btn = 4'hF;
    pulses  = 0;
    for (int i = 1; i <= SC + 4; i++) begin
      tick(1);
      if (released[2]) pulses++;
      chk_all($sformatf("settle%0d", i), (i >= SC + 2) ? 4'h0 : 4'h4, 4'h0,
              (i == SC + 2) ? 4'h4 : 4'h0);
    end
    chk("release_pulses", 4'(pulses), 4'h1);

    // btn1 glitches of 5 cycles are rejected
    for (int rep = 0; rep < 3; rep++) begin
      raw_btn = 4'hD;
      for (int j = 0; j < 5; j++) begin
        tick(1);
        chk_all($sformatf("glitch_lo%0d_%0d", rep, j), 4'h0, 4'h0, 4'h0);
      end
      raw_btn = 4'hF;
      for (int j = 0; j < 5; j++) begin
        tick(1);
        chk_all($sformatf("glitch_hi%0d_%0d", rep, j), 4'h0, 4'h0, 4'h0);
      end
    end
    tick(SC + 2);
    chk_all("glitch_after", 4'h0, 4'h0, 4'h0);

    // reset mid-debounce: btn1 fully held, btn0 at count 5
    raw_btn = 4'hD;
    tick(SC + 2);
    chk_all("pre_rst_hold", 4'h2, 4'h2, 4'h0);
    raw_btn = 4'hC;
    tick(SC);
    chk_all("pre_rst_cnt5", 4'h2, 4'h0, 4'h0);
    rst = 1'b1;
    #1;
    chk_all("rst_async", 4'h0, 4'h0, 4'h0);
    tick(3);
    chk_all("rst_hold", 4'h0, 4'h0, 4'h0);
    rst = 1'b0;
    tick(SC + 1);
    chk_all("redeb_before", 4'h0, 4'h0, 4'h0);
    tick(1);
    chk_all("redeb_fire", 4'h3, 4'h3, 4'h0);
    tick(1);
    chk_all("redeb_after", 4'h3, 4'h0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
